// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path: deserializer state encoding,
// frame geometry and default parameters.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS         = 11;
  localparam int DATA_BITS          = FRAME_BITS - 3;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  // PS/2 uses odd parity: data plus parity bit must carry an odd number of ones
  function automatic logic odd_weight(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO. Head entry is presented on data_o while
// valid_o is high; data_o reads 0 when empty. A push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is
// dropped and overflow_o pulses for one cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q;
  logic             pop_eff, push_eff, ovf_d;

  assign valid_o  = (cnt_q != '0);
  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop_i && valid_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign ovf_d    = push_i && full_o && !pop_eff;

  // Occupancy follows the accepted push/pop pair
  always_comb begin
    cnt_d = cnt_q;
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset; empty entries are masked on the output
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 clock/data lines,
// deserializes 11-bit frames on falling clock edges, checks odd parity and
// the stop bit, and buffers good bytes in a show-ahead FIFO.
// Optional partial-frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iReadEnable,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFull,
  output logic       oParityError,
  output logic       oFrameError,
  output logic       oOverflow
);

  logic [1:0] clk_s_q, dat_s_q;
  logic       clk_prev_q;
  logic       fall, dat;

  ps2_state_e state_q, state_d;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       par_q;
  logic       timeout;

  logic       push_d, perr_d, ferr_d;
  logic       perr_q, ferr_q;

  // Two-flop synchronizers plus one history flop for edge detection; idle lines sit high
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_s_q    <= {clk_s_q[0], PS2_CLK};
      dat_s_q    <= {dat_s_q[0], PS2_DATA};
      clk_prev_q <= clk_s_q[1];
    end
  end

  assign fall = clk_prev_q && !clk_s_q[1];
  assign dat  = dat_s_q[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Cycles since the last falling edge while a frame is in progress
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                           tmo_q <= '0;
    else if (state_q == ST_IDLE || fall) tmo_q <= '0;
    else                                 tmo_q <= tmo_q + 1'b1;
  end

  assign timeout = (state_q != ST_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  wire unused_tmo = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: advance one step per falling edge; a timeout abandons the frame
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   state_d = dat ? ST_IDLE : ST_DATA;
        ST_DATA:   state_d = (bit_cnt_q == 3'(DATA_BITS - 1)) ? ST_PARITY : ST_DATA;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: verdict on the frame at the stop-bit edge; parity outranks stop
  always_comb begin
    push_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    if (fall && state_q == ST_STOP) begin
      if (!odd_weight({par_q, shift_q})) perr_d = 1'b1;
      else if (!dat)                     ferr_d = 1'b1;
      else                               push_d = 1'b1;
    end
    if (timeout) ferr_d = 1'b1;
  end

  // Deserializer datapath: LSB arrives first, so shift in from the top
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   bit_cnt_q <= '0;
        ST_DATA: begin
          shift_q   <= {dat, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        ST_PARITY: par_q <= dat;
        default:   ;
      endcase
    end
  end

  // Registered one-cycle error pulses
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end

  assign oParityError = perr_q;
  assign oFrameError  = ferr_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push_i     (push_d),
    .data_i     (shift_q),
    .pop_i      (iReadEnable),
    .data_o     (oData),
    .valid_o    (oValid),
    .full_o     (oFull),
    .overflow_o (oOverflow)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framed byte reception, show-ahead reads,
// parity/frame errors, full/overflow behaviour, reset mid-frame and (when
// PS2_RX_TIMEOUT_EN is defined) the partial-frame timeout.
module tb_ps2_rx_fifo;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       iReadEnable;
  logic [7:0] oData;
  logic       oValid, oFull, oParityError, oFrameError, oOverflow;

  int n_chk  = 0;
  int n_pass = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .PS2_CLK      (PS2_CLK),
    .PS2_DATA     (PS2_DATA),
    .iReadEnable  (iReadEnable),
    .oData        (oData),
    .oValid       (oValid),
    .oFull        (oFull),
    .oParityError (oParityError),
    .oFrameError  (oFrameError),
    .oOverflow    (oOverflow)
  );

  always #5 Clock = ~Clock;

  // Pulse counters: number of cycles each error/overflow output was high
  always @(posedge Clock) begin
    if (!Reset) begin
      pe_cnt = pe_cnt + int'(oParityError);
      fe_cnt = fe_cnt + int'(oFrameError);
      ov_cnt = ov_cnt + int'(oOverflow);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_cnt();
    @(negedge Clock);
    pe_cnt = 0; fe_cnt = 0; ov_cnt = 0;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip, input logic stop);
    logic par;
    par = ~(^b) ^ flip;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic v);
    @(negedge Clock) PS2_DATA = v;
    repeat (4) @(negedge Clock);
    PS2_CLK = 1'b0;
    repeat (8) @(negedge Clock);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  // Full frame; the stop edge is timed to the system clock so a read can land
  // exactly on the push cycle and the visibility latency can be checked.
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop,
                            input logic rd, input logic lat);
    logic [10:0] f;
    f = mk_frame(b, flip, stop);
    send_bits(f, 10);
    @(negedge Clock) PS2_DATA = f[10];
    repeat (4) @(negedge Clock);
    PS2_CLK = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    if (lat) chk("valid_before_push", oValid, 1'b0);
    @(negedge Clock) iReadEnable = rd;
    @(posedge Clock);
    #1;
    if (lat) begin
      chk("valid_after_push", oValid, 1'b1);
      chk("data_after_push", oData, 8'h1C);
    end
    @(negedge Clock) iReadEnable = 1'b0;
    repeat (6) @(negedge Clock);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge Clock);
    chk({tag, "_valid"}, oValid, 1'b1);
    chk({tag, "_data"}, oData, exp);
    iReadEnable = 1'b1;
    @(negedge Clock) iReadEnable = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; iReadEnable = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_data", oData, 8'h00);
    chk("rst_valid", oValid, 1'b0);
    chk("rst_full", oFull, 1'b0);
    chk("rst_errs", {oParityError, oFrameError, oOverflow}, 3'b000);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // Single good frame, push visible one cycle after the stop edge is seen
    clr_cnt();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("f1c_errs", pe_cnt + fe_cnt + ov_cnt, 0);
    pop_chk("f1c_pop", 8'h1C);
    chk("f1c_empty", oValid, 1'b0);

    // Read on empty FIFO is ignored
    @(negedge Clock) iReadEnable = 1'b1;
    @(negedge Clock) iReadEnable = 1'b0;
    chk("empty_rd_valid", oValid, 1'b0);

    // Two frames queued, read back in order
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    pop_chk("two_f0", 8'hF0);
    pop_chk("two_1c", 8'h1C);
    chk("two_empty", oValid, 1'b0);

    // Bad parity: dropped, one-cycle parity pulse
    clr_cnt();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_pe", pe_cnt, 1);
    chk("par_fe", fe_cnt, 0);
    chk("par_valid", oValid, 1'b0);

    // Good parity, stop bit 0: frame error
    clr_cnt();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_fe", fe_cnt, 1);
    chk("stop_pe", pe_cnt, 0);
    chk("stop_valid", oValid, 1'b0);

    // Bad parity and bad stop: parity wins
    clr_cnt();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_pe", pe_cnt, 1);
    chk("both_fe", fe_cnt, 0);

    // Stray edge with data high while idle is not a start bit
    clr_cnt();
    send_bit(1'b1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("noise_errs", pe_cnt + fe_cnt, 0);
    pop_chk("noise_55", 8'h55);

    // Fill to depth, overflow on the ninth byte
    clr_cnt();
    for (int i = 0; i < 7; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fill7_full", oFull, 1'b0);
    send_frame(8'h17, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fill8_full", oFull, 1'b1);
    chk("fill8_ov", ov_cnt, 0);
    send_frame(8'h18, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fill9_ov", ov_cnt, 1);
    chk("fill9_full", oFull, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 8'h10 + 8'(i));
    chk("ovf_empty", oValid, 1'b0);

    // Full FIFO with a pop on the push cycle: both happen, no overflow
    clr_cnt();
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h28, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pp_ov", ov_cnt, 0);
    chk("pp_full", oFull, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("pp_pop", 8'h21 + 8'(i));
    chk("pp_empty", oValid, 1'b0);

    // Reset mid-frame discards the partial byte silently
    clr_cnt();
    send_bits(mk_frame(8'hAB, 1'b0, 1'b1), 6);
    @(negedge Clock) Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("midrst_valid", oValid, 1'b0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_errs", pe_cnt + fe_cnt + ov_cnt, 0);
    pop_chk("midrst_1c", 8'h1C);
    chk("midrst_empty", oValid, 1'b0);

`ifdef PS2_RX_TIMEOUT_EN
    // Start + 4 data bits then silence: frame error 100 cycles after the last edge
    clr_cnt();
    begin
      logic [10:0] f;
      f = mk_frame(8'hFF, 1'b0, 1'b1);
      send_bits(f, 4);
      @(negedge Clock) PS2_DATA = f[4];
      repeat (4) @(negedge Clock);
      PS2_CLK = 1'b0;
      for (int k = 1; k <= 104; k++) begin
        @(posedge Clock);
        #1;
        if (k == 10) PS2_CLK = 1'b1;
        if (k == 102) chk("tmo_before", oFrameError, 1'b0);
        if (k == 103) chk("tmo_pulse", oFrameError, 1'b1);
        if (k == 104) chk("tmo_after", oFrameError, 1'b0);
      end
    end
    repeat (4) @(negedge Clock);
    chk("tmo_fe_cnt", fe_cnt, 1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    pop_chk("tmo_1c", 8'h1C);
    chk("tmo_fe_final", fe_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning number of received scan-code bytes buffered; power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning Clock cycles without a PS2_CLK falling edge before a partial frame is abandoned.
REQ-003 SHALL have port Clock  input  1  system clock; one clock domain; all state is on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PS2_CLK  input  1  raw keyboard clock, asynchronous to Clock.
REQ-006 SHALL have port PS2_DATA  input  1  raw keyboard data, asynchronous to Clock.
REQ-007 SHALL have port iReadEnable  input  1  pop request from the consumer.
REQ-008 SHALL have port oData  output  8  head-of-FIFO byte, valid while oValid=1 (show-ahead).
REQ-009 SHALL have port oValid  output  1  FIFO not empty.
REQ-010 SHALL have port oFull  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port oParityError  output  1  one-cycle pulse, frame dropped for bad parity.
REQ-012 SHALL have port oFrameError  output  1  one-cycle pulse, frame dropped for stop bit 0 or timeout.
REQ-013 SHALL have port oOverflow  output  1  one-cycle pulse, good byte dropped because FIFO full.

Function
REQ-014 SHALL pass PS2_CLK and PS2_DATA each through a 2-flop synchronizer; a falling edge is synchronized PS2_CLK previous=1, current=0.
REQ-015 SHALL sample synchronized PS2_DATA only on falling edges; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-016 SHALL use FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on edge with data=0 (data=1 stays IDLE, no error); DATA->PARITY after 8th bit; PARITY->STOP after parity bit; STOP->IDLE on next edge.
REQ-017 SHALL, at the STOP edge, push the byte when stop=1 and the 9-bit data+parity has odd weight; otherwise drop it and pulse oParityError (parity bad) or oFrameError (stop=0, parity good); parity check takes precedence.
REQ-018 SHALL make a pushed byte visible on oData/oValid the cycle after the stop-bit edge is detected (one-cycle latency from edge detection).
REQ-019 SHALL pop on iReadEnable=1 with oValid=1; iReadEnable with FIFO empty SHALL be ignored.
REQ-020 SHALL, on simultaneous push and pop, perform both, occupancy unchanged, including when full (no overflow).
REQ-021 SHALL, on push while full without pop, drop the new byte, keep contents, pulse oOverflow.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH, with occupancy counter 0..FIFO_DEPTH.

Reset
REQ-023 SHALL, while Reset=1, force FSM to IDLE, shift register and bit counter to 0, FIFO empty, synchronizer flops to 1, timeout counter 0.
REQ-024 SHALL drive outputs on reset: oData=0x00, oValid=0, oFull=0, all error pulses 0.
REQ-025 SHALL discard a partially received frame when Reset asserts mid-frame; no error pulse.

Configuration
REQ-026 SHALL, with PS2_RX_TIMEOUT_EN defined, count Clock cycles in non-IDLE states, clear on each falling edge, and at TIMEOUT_CYCLES return to IDLE, drop the frame, pulse oFrameError.
REQ-027 SHALL, without PS2_RX_TIMEOUT_EN, omit the counter; FSM waits indefinitely for edges.

Structure
REQ-028 SHALL place FSM state encodings, frame bit count (11) and default parameters in the shared definitions package.
REQ-029 SHALL implement the buffer as sub-module sync_fifo (show-ahead, parameter width/depth); deserializer FSM stays in ps2_rx_fifo.

Verification
REQ-030 SHALL cover: frame 0x1C (parity 0, stop 1) -> oData=0x1C, oValid=1 one cycle after stop edge, no error pulse.
REQ-031 SHALL cover: frames 0xF0 (parity 1) then 0x1C, no reads -> FIFO holds F0,1C; two reads return 0xF0 then 0x1C, oValid=0 after.
REQ-032 SHALL cover: 0x1C sent with parity 1 -> oParityError pulse 1 cycle, oValid stays 0.
REQ-033 SHALL cover: 9 good frames with FIFO_DEPTH=8, no reads -> oFull=1 after 8th, oOverflow pulse on 9th, first 8 bytes intact; 9th frame with concurrent iReadEnable -> no overflow, occupancy 8.
REQ-034 SHALL cover: PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100, stop edges after 4 data bits -> oFrameError at cycle 100, next full frame 0x1C received correctly.
REQ-035 SHALL cover: Reset asserted after 5 data bits of a frame, released, then frame 0x1C -> only 0x1C in FIFO, no error pulses.
